// File: rtl/cmac_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// cmac_tx_arb_pkg
// Shared types and constants for the CMAC transmit arbiter and its
// round-robin picker.
//   arb_state_e : arbiter FSM state (IDLE, XFER)
//   DEF_*       : default parameter values for the arbiter
//   idx_w()     : width of a source index, never less than one bit
// -----------------------------------------------------------------------------
package cmac_tx_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_SRC    = 32'd4;
  localparam int unsigned DEF_DATA_WIDTH = 32'd512;
  localparam int unsigned DEF_CNT_WIDTH  = 32'd32;

  // Index width for n sources; a single source still needs a one-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage : cmac_tx_arb_pkg

// File: rtl/cmac_tx_rr_picker.sv
// -----------------------------------------------------------------------------
// cmac_tx_rr_picker
// Purely combinational round-robin selector. Searches req cyclically starting
// at (rr_ptr+1) mod NUM_SRC and returns the first set index.
//   req    in  NUM_SRC  request vector
//   rr_ptr in  IW       index granted last time
//   any    out 1        at least one request is set
//   pick   out IW       selected index (0 when any is 0)
// -----------------------------------------------------------------------------
module cmac_tx_rr_picker
  import cmac_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC
) (
  input  logic [NUM_SRC-1:0]          req,
  input  logic [idx_w(NUM_SRC)-1:0]   rr_ptr,
  output logic                        any,
  output logic [idx_w(NUM_SRC)-1:0]   pick
);

  localparam int unsigned IW = idx_w(NUM_SRC);

  logic [IW-1:0] idx_s;

  // Scan from the farthest candidate to the nearest so the nearest set
  // request after rr_ptr is the last one written and therefore wins.
  always_comb begin
    any   = 1'b0;
    pick  = {IW{1'b0}};
    idx_s = {IW{1'b0}};
    for (int unsigned k = NUM_SRC; k >= 32'd1; k--) begin
      idx_s = IW'((32'(rr_ptr) + k) % NUM_SRC);
      any   = any | req[idx_s];
      pick  = req[idx_s] ? idx_s : pick;
    end
  end

endmodule : cmac_tx_rr_picker

// File: rtl/cmac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// cmac_tx_arbiter
// Packet-level round-robin arbiter sharing the CMAC transmit AXI4-Stream among
// NUM_SRC sources. A grant lasts from the first beat of a packet to its tlast,
// so packets never interleave. The output stage is a single register slice.
//   CLK, RST_N            clock and async active-low reset
//   S_TVALID/TREADY/...   per-source AXI4-Stream slave inputs (flattened)
//   M_TVALID/TREADY/...   registered AXI4-Stream master output
//   SRC_ENABLE            per-source enable, sampled only when choosing a grant
//   GRANT_ID              current or last granted source
//   BUSY                  1 while a packet is in progress
//   PKT_CNT               per-source completed-packet counters (flattened)
// -----------------------------------------------------------------------------
module cmac_tx_arbiter
  import cmac_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic [NUM_SRC-1:0]              S_TVALID,
  output logic [NUM_SRC-1:0]              S_TREADY,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_TDATA,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_TSTRB,
  input  logic [NUM_SRC-1:0]              S_TLAST,
  output logic                            M_TVALID,
  input  logic                            M_TREADY,
  output logic [DATA_WIDTH-1:0]           M_TDATA,
  output logic [DATA_WIDTH/8-1:0]         M_TSTRB,
  output logic                            M_TLAST,
  input  logic [NUM_SRC-1:0]              SRC_ENABLE,
  output logic [$clog2(NUM_SRC)-1:0]      GRANT_ID,
  output logic                            BUSY,
  output logic [NUM_SRC*CNT_WIDTH-1:0]    PKT_CNT
);

  localparam int unsigned IW = idx_w(NUM_SRC);
  localparam int unsigned SW = DATA_WIDTH / 32'd8;

  // FSM and pointer state
  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  busy_q, busy_d;

  // Output register slice
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [SW-1:0]         m_strb_q, m_strb_d;
  logic                  m_last_q, m_last_d;

  // Completed-packet counters
  logic [CNT_WIDTH-1:0]  pkt_cnt_q [NUM_SRC];
  logic [CNT_WIDTH-1:0]  pkt_cnt_d [NUM_SRC];

  // Combinational helpers
  logic [NUM_SRC-1:0]    req_s;
  logic                  any_s;
  logic [IW-1:0]         pick_s;
  logic                  sel_valid_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [SW-1:0]         sel_strb_s;
  logic                  sel_last_s;
  logic                  out_ready_s;
  logic                  accept_s;

  // Enable only matters when a new grant is being chosen.
  assign req_s = S_TVALID & SRC_ENABLE;

  cmac_tx_rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req    (req_s),
    .rr_ptr (rr_ptr_q),
    .any    (any_s),
    .pick   (pick_s)
  );

  // Input mux follows the held grant.
  assign sel_valid_s = S_TVALID[grant_q];
  assign sel_data_s  = S_TDATA[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb_s  = S_TSTRB[32'(grant_q) * SW +: SW];
  assign sel_last_s  = S_TLAST[grant_q];

  // The output slice can take a beat when empty or draining this cycle.
  assign out_ready_s = ~m_valid_q | M_TREADY;
  assign accept_s    = (state_q == XFER) & sel_valid_s & out_ready_s;

  // Ready is steered only to the granted source while a packet is open.
  always_comb begin
    S_TREADY = {NUM_SRC{1'b0}};
    if (state_q == XFER) begin
      S_TREADY[grant_q] = out_ready_s;
    end else begin
      S_TREADY = {NUM_SRC{1'b0}};
    end
  end

  // Next-state, grant, pointer and counter update.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d = XFER;
          grant_d = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (accept_s && sel_last_s) begin
          state_d            = IDLE;
          rr_ptr_d           = grant_q;
          pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_WIDTH'(1);
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == XFER);
  end

  // Output register: load on accept, drop valid once drained, else hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_strb_d  = m_strb_q;
    m_last_d  = m_last_q;
    if (accept_s) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data_s;
      m_strb_d  = sel_strb_s;
      m_last_d  = sel_last_s;
    end else if (M_TREADY) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // FSM state register; rr_ptr resets to the top index so source 0 wins first.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      grant_q  <= {IW{1'b0}};
      rr_ptr_q <= IW'(NUM_SRC - 32'd1);
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  // Output register slice and packet counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_q <= 1'b0;
      m_data_q  <= {DATA_WIDTH{1'b0}};
      m_strb_q  <= {SW{1'b0}};
      m_last_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        pkt_cnt_q[i] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_strb_q  <= m_strb_d;
      m_last_q  <= m_last_d;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        pkt_cnt_q[i] <= pkt_cnt_d[i];
      end
    end
  end

  assign M_TVALID = m_valid_q;
  assign M_TDATA  = m_data_q;
  assign M_TSTRB  = m_strb_q;
  assign M_TLAST  = m_last_q;
  assign GRANT_ID = grant_q;
  assign BUSY     = busy_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign PKT_CNT[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
  end

endmodule : cmac_tx_arbiter

// File: tb/tb_cmac_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cmac_tx_arbiter
// Scoreboard bench: each test queues source packets and pushes the beats and
// grants it predicts onto expected queues; the per-cycle monitor pops them as
// the DUT produces output. A 4-bit counter build exercises wrap-around.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cmac_tx_arbiter;

  localparam int NS = 4;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  localparam int CW = 4;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NS-1:0]     s_tvalid = '0;
  logic [NS-1:0]     s_tready;
  logic [NS*DW-1:0]  s_tdata = '0;
  logic [NS*SW-1:0]  s_tstrb = '0;
  logic [NS-1:0]     s_tlast = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DW-1:0]     m_tdata;
  logic [SW-1:0]     m_tstrb;
  logic              m_tlast;
  logic [NS-1:0]     src_en = '1;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic [NS*CW-1:0]  pkt_cnt;

  cmac_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(clk), .RST_N(rst_n),
    .S_TVALID(s_tvalid), .S_TREADY(s_tready), .S_TDATA(s_tdata),
    .S_TSTRB(s_tstrb), .S_TLAST(s_tlast),
    .M_TVALID(m_tvalid), .M_TREADY(m_tready), .M_TDATA(m_tdata),
    .M_TSTRB(m_tstrb), .M_TLAST(m_tlast),
    .SRC_ENABLE(src_en), .GRANT_ID(grant_id), .BUSY(busy), .PKT_CNT(pkt_cnt)
  );

  initial forever #5 clk = ~clk;

  beat_t src_q[NS][$];
  beat_t exp_q[$];
  int    exp_grant_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int exp_gap = 0;
  int exp_busy_len = 0;
  int low_run = 0;
  int high_run = 0;
  int stall_cnt = 0;
  bit prev_busy = 1'b0;
  bit had_busy = 1'b0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_strb;
  logic          prev_last;

  function automatic logic [CW-1:0] get_cnt(input int i);
    return pkt_cnt[i*CW +: CW];
  endfunction

  task automatic make_pkt(input int src, input int len, input bit exp_out);
    beat_t b;
    logic [SW-1:0] full;
    int nb;
    full = {SW{1'b1}};
    for (int k = 0; k < len; k++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom();
      if (k == len - 1) begin
        nb = $urandom_range(SW, 1);
        b.strb = full >> (SW - nb);
        b.last = 1'b1;
      end else begin
        b.strb = full;
        b.last = 1'b0;
      end
      src_q[src].push_back(b);
      if (exp_out) exp_q.push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample and score 1 time unit before posedge.
  task automatic cycle();
    beat_t b;
    logic [NS-1:0] exp_rdy;
    int g;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i] = 1'b1;
        s_tdata[i*DW +: DW] = b.data;
        s_tstrb[i*SW +: SW] = b.strb;
        s_tlast[i] = b.last;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i] = 1'b0;
      end
    end
    m_tready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2 == 0) ? 1'b1 : 1'b0);
    #4;
    if (stall_prev) begin
      tests++;
      stall_cnt++;
      if (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tstrb !== prev_strb || m_tlast !== prev_last) begin
        fails++;
        $display("FAIL stall_hold: cycle %0d got valid=%b last=%b data[31:0]=%h, required valid=1 last=%b data[31:0]=%h",
                 cyc, m_tvalid, m_tlast, m_tdata[31:0], prev_last, prev_data[31:0]);
      end
    end
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_beat: cycle %0d got unexpected beat data[31:0]=%h, required no beat", cyc, m_tdata[31:0]);
      end else begin
        b = exp_q.pop_front();
        if (m_tdata !== b.data || m_tstrb !== b.strb || m_tlast !== b.last) begin
          fails++;
          $display("FAIL out_beat: cycle %0d got data[31:0]=%h strb=%h last=%b, required data[31:0]=%h strb=%h last=%b",
                   cyc, m_tdata[31:0], m_tstrb, m_tlast, b.data[31:0], b.strb, b.last);
        end
      end
    end
    exp_rdy = '0;
    if (busy === 1'b1) exp_rdy[grant_id] = ~m_tvalid | m_tready;
    tests++;
    if (s_tready !== exp_rdy) begin
      fails++;
      $display("FAIL s_tready: cycle %0d got %b, required %b", cyc, s_tready, exp_rdy);
    end
    if (busy === 1'b1 && !prev_busy) begin
      tests++;
      if (exp_grant_q.size() == 0) begin
        fails++;
        $display("FAIL grant: cycle %0d got unexpected grant %0d, required none", cyc, grant_id);
      end else begin
        g = exp_grant_q.pop_front();
        if (int'(grant_id) != g) begin
          fails++;
          $display("FAIL grant: cycle %0d got %0d, required %0d", cyc, grant_id, g);
        end
      end
      if (had_busy && exp_gap > 0) begin
        tests++;
        if (low_run != exp_gap) begin
          fails++;
          $display("FAIL idle_gap: cycle %0d got %0d idle cycles, required %0d", cyc, low_run, exp_gap);
        end
      end
      high_run = 1;
    end else if (busy === 1'b1) begin
      high_run++;
    end
    if (busy !== 1'b1 && prev_busy) begin
      had_busy = 1'b1;
      low_run = 1;
      if (exp_busy_len > 0) begin
        tests++;
        if (high_run != exp_busy_len) begin
          fails++;
          $display("FAIL busy_len: cycle %0d got %0d busy cycles, required %0d", cyc, high_run, exp_busy_len);
        end
      end
    end else if (busy !== 1'b1) begin
      low_run++;
    end
    prev_busy = (busy === 1'b1);
    for (int i = 0; i < NS; i++) begin
      if (s_tvalid[i] && s_tready[i] === 1'b1) void'(src_q[i].pop_front());
    end
    stall_prev = (m_tvalid === 1'b1 && m_tready === 1'b0);
    prev_data = m_tdata;
    prev_strb = m_tstrb;
    prev_last = m_tlast;
    cyc++;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    exp_grant_q.delete();
    s_tvalid = '0;
    s_tlast = '0;
    src_en = '1;
    rdy_mode = 0;
    m_tready = 1'b1;
    stall_prev = 1'b0;
    prev_busy = 1'b0;
    had_busy = 1'b0;
    low_run = 0;
    high_run = 0;
    exp_gap = 0;
    exp_busy_len = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    clear_bench();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_grant_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    tests++;
    if (exp_q.size() > 0 || exp_grant_q.size() > 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d beats and %0d grants outstanding after %0d cycles, required 0",
               name, exp_q.size(), exp_grant_q.size(), n);
    end
    repeat (3) cycle();
  endtask

  task automatic check_cnt(input string name, input int src, input int exp_val);
    tests++;
    if (get_cnt(src) !== CW'(exp_val)) begin
      fails++;
      $display("FAIL %s: pkt_cnt[%0d] got %0d, required %0d", name, src, get_cnt(src), exp_val);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tlast !== 1'b0) begin
      fails++;
      $display("FAIL %s_m: got valid=%b last=%b data[31:0]=%h strb[15:0]=%h, required all 0",
               name, m_tvalid, m_tlast, m_tdata[31:0], m_tstrb[15:0]);
    end
    tests++;
    if (s_tready !== '0 || grant_id !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_ctl: got s_tready=%b grant=%0d busy=%b, required 0/0/0", name, s_tready, grant_id, busy);
    end
    tests++;
    if (pkt_cnt !== '0) begin
      fails++;
      $display("FAIL %s_cnt: got pkt_cnt=%h, required 0", name, pkt_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = '1;
    s_tlast = '1;
    for (int w = 0; w < NS * DW / 32; w++) s_tdata[w*32 +: 32] = $urandom();
    s_tstrb = '1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset_dut();
  endtask

  task automatic test_single_pkt();
    bit exp_b;
    bit exp_v;
    reset_dut();
    make_pkt(2, 3, 1'b1);
    exp_grant_q.push_back(2);
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_b = (k >= 1 && k <= 3);
      exp_v = (k >= 2 && k <= 4);
      tests++;
      if (busy !== exp_b || m_tvalid !== exp_v || (m_tvalid & m_tlast) !== (k == 4)) begin
        fails++;
        $display("FAIL single_timing: step %0d got busy=%b valid=%b last=%b, required busy=%b valid=%b last=%b",
                 k, busy, m_tvalid, m_tvalid & m_tlast, exp_b, exp_v, (k == 4));
      end
      if (k == 1) begin
        tests++;
        if (grant_id !== 2'd2 || s_tready !== 4'b0100) begin
          fails++;
          $display("FAIL single_grant: got grant=%0d s_tready=%b, required 2 and 0100", grant_id, s_tready);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_beats: %0d beats missing, required 0", exp_q.size());
    end
    check_cnt("single_cnt", 2, 1);
    check_cnt("single_cnt_other", 0, 0);
  endtask

  task automatic test_round_robin();
    reset_dut();
    exp_gap = 1;
    exp_busy_len = 2;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < NS; s++) begin
        make_pkt(s, 2, 1'b1);
        exp_grant_q.push_back(s);
      end
    end
    run_until_done("rr", 120);
    for (int s = 0; s < NS; s++) check_cnt("rr_cnt", s, 2);
  endtask

  task automatic test_backpressure();
    reset_dut();
    stall_cnt = 0;
    rdy_mode = 1;
    make_pkt(1, 4, 1'b1);
    exp_grant_q.push_back(1);
    run_until_done("bp", 60);
    rdy_mode = 0;
    tests++;
    if (stall_cnt == 0) begin
      fails++;
      $display("FAIL bp_stalls: got 0 stall cycles, required at least 1");
    end
    check_cnt("bp_cnt", 1, 1);
  endtask

  task automatic test_enable();
    int n;
    reset_dut();
    make_pkt(0, 3, 1'b1);
    exp_grant_q.push_back(0);
    make_pkt(0, 2, 1'b0);
    make_pkt(3, 2, 1'b1);
    exp_grant_q.push_back(3);
    make_pkt(3, 2, 1'b1);
    exp_grant_q.push_back(3);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    cycle();
    src_en[0] = 1'b0;
    run_until_done("en", 60);
    repeat (5) cycle();
    check_cnt("en_cnt0", 0, 1);
    check_cnt("en_cnt3", 3, 2);
    tests++;
    if (src_q[0].size() != 2) begin
      fails++;
      $display("FAIL en_pending: source 0 queue got %0d beats, required 2", src_q[0].size());
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    make_pkt(2, 4, 1'b1);
    exp_grant_q.push_back(2);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    clear_bench();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    make_pkt(1, 2, 1'b1);
    exp_grant_q.push_back(1);
    run_until_done("post_reset", 40);
    check_cnt("post_reset_cnt1", 1, 1);
    check_cnt("post_reset_cnt2", 2, 0);
  endtask

  task automatic test_wrap();
    reset_dut();
    exp_gap = 1;
    exp_busy_len = 1;
    for (int p = 0; p < 15; p++) begin
      make_pkt(0, 1, 1'b1);
      exp_grant_q.push_back(0);
    end
    run_until_done("wrap_a", 100);
    check_cnt("wrap_15", 0, 15);
    exp_gap = 0;
    for (int p = 0; p < 2; p++) begin
      make_pkt(0, 1, 1'b1);
      exp_grant_q.push_back(0);
    end
    run_until_done("wrap_b", 30);
    check_cnt("wrap_17", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cmac_tx_arbiter

// File: doc/cmac_tx_arbiter.md
# cmac_tx_arbiter

Packet-level round-robin arbiter that shares the single 512-bit CMAC transmit AXI4-Stream among NUM_SRC requesters. It sits directly upstream of the AXI-to-LBUS converter in the CMAC clock domain. A grant is held from the first beat of a packet to its tlast, so beats of different packets never interleave. The output is registered, and the block keeps per-source transmitted-packet counters for status.

## Interface
Parameters:
- NUM_SRC, 4: number of requesting streams, range 2..8.
- DATA_WIDTH, 512: tdata width; tstrb width is DATA_WIDTH/8.
- CNT_WIDTH, 32: width of each packet counter.

Ports:
- CLK  in  1  CMAC TX user clock; the only clock.
- RST_N  in  1  reset, asynchronous assert, active-low.
- S_TVALID  in  NUM_SRC  per-source valid.
- S_TREADY  out  NUM_SRC  per-source ready.
- S_TDATA  in  NUM_SRC*DATA_WIDTH  source i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- S_TSTRB  in  NUM_SRC*DATA_WIDTH/8  per-source byte strobes, contiguous from bit 0.
- S_TLAST  in  NUM_SRC  per-source end of packet.
- M_TVALID  out  1  registered output valid.
- M_TREADY  in  1  tready from the LBUS converter.
- M_TDATA  out  DATA_WIDTH  registered data.
- M_TSTRB  out  DATA_WIDTH/8  registered strobes.
- M_TLAST  out  1  registered last.
- SRC_ENABLE  in  NUM_SRC  configuration; a source whose bit is 0 is never newly granted.
- GRANT_ID  out  $clog2(NUM_SRC)  index of the current or last granted source.
- BUSY  out  1  1 while a packet is in progress.
- PKT_CNT  out  NUM_SRC*CNT_WIDTH  number of packets completed per source.

## Operation
- FSM with two states, IDLE and XFER. Reset state is IDLE.
- IDLE:
  - Requests are req[i] = S_TVALID[i] & SRC_ENABLE[i].
  - If any request is set, pick the first set index searching cyclically from (rr_ptr+1) mod NUM_SRC.
  - Register the pick as GRANT_ID and go to XFER.
  - All S_TREADY are 0 in IDLE.
- XFER:
  - S_TREADY[GRANT_ID] = ~M_TVALID | M_TREADY. All other S_TREADY bits are 0.
  - A beat is accepted when the granted S_TVALID and S_TREADY are both 1.
  - An accepted beat is copied into the output register (data, strb, last) and M_TVALID is set to 1.
  - M_TVALID clears when M_TREADY is 1 and no new beat is accepted in that cycle.
  - When an accepted beat has S_TLAST = 1: PKT_CNT[GRANT_ID] increments, rr_ptr takes the value of GRANT_ID, and the FSM returns to IDLE.
  - PKT_CNT wraps modulo 2^CNT_WIDTH.
- SRC_ENABLE is sampled only in IDLE. Deasserting enable mid-packet does not truncate that packet.
- A source whose tvalid drops mid-packet stalls the output. The grant is held, and there is no timeout.
- Strobes pass through unmodified. Keeping them contiguous is the sources' responsibility.
- RST_N low, including mid-packet:
  - State returns to IDLE immediately.
  - M_TVALID=0, M_TDATA=0, M_TSTRB=0, M_TLAST=0.
  - S_TREADY=0, GRANT_ID=0, BUSY=0, rr_ptr=NUM_SRC-1 (so source 0 wins first), all PKT_CNT=0.
  - A partially sent packet is abandoned. The downstream converter shares this reset.

## Timing
- Grant latency is 1 cycle: a request seen in IDLE in cycle n gives GRANT_ID, BUSY and S_TREADY valid in cycle n+1.
- Data latency is 1 cycle: a beat accepted in cycle n appears on M_T* in cycle n+1.
- Inter-packet gap: 1 IDLE cycle between packets. With M_TREADY held at 1, throughput is L/(L+1) beats per cycle for L-beat packets.
- BUSY is 1 exactly while the state is XFER.
- Under backpressure the output register holds its contents stable. This follows AXI4-Stream rules: no change of M_T* while M_TVALID=1 and M_TREADY=0.
- A single-beat packet spends one cycle in XFER.
- Every output is registered except S_TREADY, which is combinational from the state, M_TVALID and M_TREADY.

## Structure
- Package cmac_tx_arb_pkg holds:
  - the state enum (IDLE, XFER);
  - the default parameter constants;
  - the function idx_w(NUM_SRC) = max(1, $clog2(NUM_SRC)).
- Sub-module cmac_tx_rr_picker is purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: any, pick index.
  - It is reused by the RX-side queue scheduler.
- The top level contains the FSM, the output register, the input mux and the counters.

## Test plan
- Reset, then a 3-beat packet on source 2 only, M_TREADY=1: GRANT_ID=2 after 1 cycle; beats appear on M_T* at cycles 2..4 after the request; tlast on the third beat; PKT_CNT[2]=1.
- Sources 0..3 each hold tvalid with 2-beat packets continuously: grant order 0,1,2,3,0,…; each grant followed by one IDLE cycle; after 8 packets every PKT_CNT=2.
- M_TREADY toggles 1010 during a 4-beat packet from source 1: no beat lost or duplicated, M_T* stable while stalled, S_TREADY[1] correct every cycle.
- SRC_ENABLE[0] cleared mid-packet of source 0: packet completes; with sources 0 and 3 still requesting afterwards, only source 3 is granted.
- RST_N pulsed low for 1 cycle mid-packet: all outputs go to reset values asynchronously; after release a fresh packet from source 1 is granted cleanly.
- Preload PKT_CNT near 2^CNT_WIDTH-1 via a CNT_WIDTH=4 build and send 17 packets on source 0: count wraps to 1.
